ps2_player_cmd: RTL and testbench
=================================

PS2_PLAYER_CMD -- requirements
Module: ps2_player_cmd

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 65000, is the number of clk cycles without a ps2_clk falling edge after which a partial frame is aborted.
REQ-002 clk  input  1  system clock.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 ps2_clk  input  1  PS/2 keyboard clock, asynchronous to clk.
REQ-005 ps2_data  input  1  PS/2 keyboard data, asynchronous to clk.
REQ-006 m_left  output  1  level, high while the player is to move left.
REQ-007 m_right  output  1  level, high while the player is to move right.
REQ-008 code  output  8  last correctly received scan-code byte.
REQ-009 code_valid  output  1  one-cycle pulse when code is updated.
REQ-010 frame_err  output  1  one-cycle pulse on a discarded frame.

Function
REQ-011 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer; a falling edge SHALL be detected on the synchronized ps2_clk against its registered previous value.
REQ-012 The receiver FSM SHALL have states IDLE, DATA, PARITY, STOP; the data bit SHALL be sampled on each detected falling edge.
REQ-013 IDLE: a falling edge with data 0 SHALL go to DATA with bit counter 0; a falling edge with data 1 SHALL stay in IDLE with no pulse.
REQ-014 DATA: eight bits SHALL be shifted LSB first, then go to PARITY; PARITY: the bit SHALL be stored, then go to STOP.
REQ-015 STOP: a stop bit of 1 with odd parity over the 8 data bits plus the parity bit SHALL load code and pulse code_valid; otherwise frame_err SHALL pulse and code SHALL keep its value; both cases return to IDLE.
REQ-016 code_valid SHALL assert no later than 4 clk cycles after the stop-bit falling edge at the ps2_clk pin.
REQ-017 In any state other than IDLE, TIMEOUT_CYCLES consecutive clk cycles without a falling edge SHALL pulse frame_err and return to IDLE.
REQ-018 The timeout counter SHALL reset on every falling edge and SHALL saturate, never wrap.
REQ-019 The decoder SHALL keep flags ext (set by byte E0) and brk (set by byte F0); a prefix byte SHALL NOT change key state.
REQ-020 A non-prefix byte SHALL be applied as a key event with the current ext/brk flags, after which both flags SHALL clear.
REQ-021 Left key = {ext,6B} or {no ext,1C}; right key = {ext,74} or {no ext,23}; make sets held_left/held_right, break clears it; all other bytes are ignored.
REQ-022 A make for an already-held key (typematic repeat) SHALL leave held state and priority unchanged.
REQ-023 A 1-bit last_dir register SHALL record the direction of the most recent make of a key that was not already held.
REQ-024 m_left = held_left and (not held_right or last_dir=left); m_right = held_right and (not held_left or last_dir=right); m_left and m_right SHALL never both be 1.
REQ-025 m_left and m_right SHALL be registered and SHALL update on the clk cycle after the code_valid pulse of the causing byte.
REQ-026 frame_err SHALL clear ext and brk and SHALL leave held keys unchanged.

Reset
REQ-027 On rst: FSM=IDLE, bit counter=0, timeout counter=0, code=8'h00, code_valid=0, frame_err=0, ext=brk=0, held_left=held_right=0, last_dir=left, m_left=m_right=0, synchronizer flops=1.
REQ-028 rst asserted mid-frame SHALL discard the partial frame without a frame_err pulse; the first frame after release SHALL decode normally.

Verification
REQ-029 Bytes E0,74 -> code_valid x2, code=8'h74, m_right=1 one cycle later, m_left=0.
REQ-030 Hold right, then send 1C -> m_left=1, m_right=0; then send F0,1C -> m_right=1 again.
REQ-031 Byte 6B sent with wrong parity -> frame_err one pulse, no code_valid, code and m_left unchanged.
REQ-032 Start bit plus 3 data bits, then ps2_clk idle for TIMEOUT_CYCLES -> frame_err pulse, FSM=IDLE, next byte 23 -> m_right=1.
REQ-033 Send 23 three times (typematic), then F0,23 -> m_right 1 throughout the repeats, 0 after the break.
REQ-034 rst asserted after 5 bits of a frame -> all outputs at reset values, no frame_err; next byte E0,6B -> m_left=1.

Source files
------------

// File: rtl/ps2_player_cmd.sv
// PS/2 keyboard receiver plus arrow/letter key decoder that turns left/right key
// make/break codes into mutually exclusive m_left/m_right move levels.
module ps2_player_cmd #(
  parameter int TIMEOUT_CYCLES = 65000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       m_left,
  output logic       m_right,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       frame_err
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_MAX  = {TO_W{1'b1}};
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

  logic            ps2_clk_s1_q, ps2_clk_s1_d, ps2_clk_s2_q, ps2_clk_s2_d;
  logic            ps2_clk_prev_q, ps2_clk_prev_d;
  logic            ps2_data_s1_q, ps2_data_s1_d, ps2_data_s2_q, ps2_data_s2_d;
  state_t          state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            parity_q, parity_d;
  logic [TO_W-1:0] timeout_q, timeout_d;
  logic [7:0]      code_q, code_d;
  logic            code_valid_q, code_valid_d;
  logic            frame_err_q, frame_err_d;
  logic            ext_q, ext_d, brk_q, brk_d;
  logic            held_left_q, held_left_d, held_right_q, held_right_d;
  logic            last_dir_q, last_dir_d;
  logic            m_left_q, m_left_d, m_right_q, m_right_d;
  logic            fall;
  logic            is_left, is_right;

  assign fall = ps2_clk_prev_q & ~ps2_clk_s2_q;

  // Synchronizers and frame receiver with inactivity timeout
  always_comb begin
    ps2_clk_s1_d   = ps2_clk;
    ps2_clk_s2_d   = ps2_clk_s1_q;
    ps2_clk_prev_d = ps2_clk_s2_q;
    ps2_data_s1_d  = ps2_data;
    ps2_data_s2_d  = ps2_data_s1_q;
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    shift_d        = shift_q;
    parity_d       = parity_q;
    timeout_d      = timeout_q;
    code_d         = code_q;
    code_valid_d   = 1'b0;
    frame_err_d    = 1'b0;
    if (state_q == IDLE) begin
      timeout_d = '0;
      if (fall && !ps2_data_s2_q) begin
        state_d   = DATA;
        bit_cnt_d = 3'd0;
      end else begin
        state_d = IDLE;
      end
    end else if (fall) begin
      timeout_d = '0;
      case (state_q)
        DATA: begin
          shift_d = {ps2_data_s2_q, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d = 3'd0;
            state_d   = PARITY;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
        PARITY: begin
          parity_d = ps2_data_s2_q;
          state_d  = STOP;
        end
        STOP: begin
          if (ps2_data_s2_q && odd_parity_ok(shift_q, parity_q)) begin
            code_d       = shift_q;
            code_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (timeout_q >= TO_LAST) begin
      frame_err_d = 1'b1;
      state_d     = IDLE;
      bit_cnt_d   = 3'd0;
      timeout_d   = '0;
    end else begin
      timeout_d = (timeout_q == TO_MAX) ? timeout_q : timeout_q + TO_W'(1);
    end
  end

  assign is_left  = ext_q ? (code_q == 8'h6B) : (code_q == 8'h1C);
  assign is_right = ext_q ? (code_q == 8'h74) : (code_q == 8'h23);

  // Key decoder: prefix flags, held keys and most-recent-direction priority
  always_comb begin
    ext_d        = ext_q;
    brk_d        = brk_q;
    held_left_d  = held_left_q;
    held_right_d = held_right_q;
    last_dir_d   = last_dir_q;
    if (frame_err_q) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (code_valid_q) begin
      if (code_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (code_q == 8'hF0) begin
        brk_d = 1'b1;
      end else begin
        if (is_left) begin
          if (brk_q) begin
            held_left_d = 1'b0;
          end else if (!held_left_q) begin
            held_left_d = 1'b1;
            last_dir_d  = DIR_LEFT;
          end else begin
            held_left_d = held_left_q;
          end
        end else if (is_right) begin
          if (brk_q) begin
            held_right_d = 1'b0;
          end else if (!held_right_q) begin
            held_right_d = 1'b1;
            last_dir_d   = DIR_RIGHT;
          end else begin
            held_right_d = held_right_q;
          end
        end else begin
          last_dir_d = last_dir_q;
        end
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end else begin
      last_dir_d = last_dir_q;
    end
    m_left_d  = held_left_d & (~held_right_d | (last_dir_d == DIR_LEFT));
    m_right_d = held_right_d & (~held_left_d | (last_dir_d == DIR_RIGHT));
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ps2_clk_s1_q   <= 1'b1;
      ps2_clk_s2_q   <= 1'b1;
      ps2_clk_prev_q <= 1'b1;
      ps2_data_s1_q  <= 1'b1;
      ps2_data_s2_q  <= 1'b1;
      state_q        <= IDLE;
      bit_cnt_q      <= 3'd0;
      shift_q        <= 8'h00;
      parity_q       <= 1'b0;
      timeout_q      <= '0;
      code_q         <= 8'h00;
      code_valid_q   <= 1'b0;
      frame_err_q    <= 1'b0;
      ext_q          <= 1'b0;
      brk_q          <= 1'b0;
      held_left_q    <= 1'b0;
      held_right_q   <= 1'b0;
      last_dir_q     <= DIR_LEFT;
      m_left_q       <= 1'b0;
      m_right_q      <= 1'b0;
    end else begin
      ps2_clk_s1_q   <= ps2_clk_s1_d;
      ps2_clk_s2_q   <= ps2_clk_s2_d;
      ps2_clk_prev_q <= ps2_clk_prev_d;
      ps2_data_s1_q  <= ps2_data_s1_d;
      ps2_data_s2_q  <= ps2_data_s2_d;
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      parity_q       <= parity_d;
      timeout_q      <= timeout_d;
      code_q         <= code_d;
      code_valid_q   <= code_valid_d;
      frame_err_q    <= frame_err_d;
      ext_q          <= ext_d;
      brk_q          <= brk_d;
      held_left_q    <= held_left_d;
      held_right_q   <= held_right_d;
      last_dir_q     <= last_dir_d;
      m_left_q       <= m_left_d;
      m_right_q      <= m_right_d;
    end
  end

  assign m_left     = m_left_q;
  assign m_right    = m_right_q;
  assign code       = code_q;
  assign code_valid = code_valid_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_player_cmd.sv
// Self-checking bench for ps2_player_cmd: a vector table of PS/2 frames with
// expected pulses/levels, checked through a scoreboard queue, plus timeout and reset sequences.
module tb_ps2_player_cmd;

  localparam int TO = 200;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       m_left, m_right, code_valid, frame_err;
  logic [7:0] code;

  ps2_player_cmd #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .m_left(m_left), .m_right(m_right), .code(code),
    .code_valid(code_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    bit         bad_par;
    bit         bad_stop;
    bit         exp_err;
    bit         ml;
    bit         mr;
  } vec_t;

  typedef struct {
    bit         err;
    logic [7:0] code;
    bit         ml;
    bit         mr;
  } exp_t;

  exp_t       q[$];
  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  int         last_stop_cyc = 0;
  logic [7:0] last_code = 8'h00;
  vec_t       vecs[27];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Scoreboard monitor: pops an expectation on every pulse, checks move levels one cycle later
  initial begin : monitor
    exp_t e;
    bit   m_pend;
    m_pend = 1'b0;
    forever begin
      @(negedge clk);
      if (m_left && m_right) begin
        fails++;
        $display("FAIL both_moves: m_left=%0b m_right=%0b (cycle %0d)", m_left, m_right, cyc);
      end
      if (m_pend) begin
        check("m_left", m_left, e.ml);
        check("m_right", m_right, e.mr);
        m_pend = 1'b0;
      end
      if (code_valid || frame_err) begin
        if (q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_pulse: code_valid=%0b frame_err=%0b expected none", code_valid, frame_err);
        end else begin
          e = q.pop_front();
          check("code_valid", code_valid, !e.err);
          check("frame_err", frame_err, e.err);
          check("code", code, e.code);
          if (!e.err) check("latency_le4", (cyc - last_stop_cyc) <= 4, 1);
          m_pend = 1'b1;
        end
      end
    end
  end

  task automatic send_bit(input logic b, input bit is_stop);
    @(posedge clk); #1 ps2_data = b;
    repeat (5) @(posedge clk);
    #1 ps2_clk = 1'b0;
    if (is_stop) last_stop_cyc = cyc;
    repeat (10) @(posedge clk);
    #1 ps2_clk = 1'b1;
    repeat (5) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
    logic [10:0] bits;
    bits = {~bad_stop, (~^d) ^ bad_par, d, 1'b0};
    for (int i = 0; i < 11; i++) send_bit(bits[i], i == 10);
    #1 ps2_data = 1'b1;
  endtask

  task automatic send_partial(input logic [7:0] d, input int nbits);
    logic [8:0] bits;
    bits = {d, 1'b0};
    for (int i = 0; i < nbits; i++) send_bit(bits[i], 1'b0);
    #1 ps2_data = 1'b1;
  endtask

  task automatic run_byte(input logic [7:0] d, input bit bad_par, input bit bad_stop,
                          input bit ml, input bit mr);
    exp_t e;
    bit   err;
    err    = bad_par | bad_stop;
    e.err  = err;
    e.code = err ? last_code : d;
    e.ml   = ml;
    e.mr   = mr;
    if (!err) last_code = d;
    q.push_back(e);
    send_frame(d, bad_par, bad_stop);
    repeat (10) @(posedge clk);
    check("pulse_seen", q.size(), 0);
    q.delete();
  endtask

  initial begin
    vecs[0]  = '{8'hE0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{8'h74, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{8'h1C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{8'h1C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{8'h6B, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[6]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{8'h74, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{8'hE0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{8'h74, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{8'h23, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{8'h23, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{8'h23, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[14] = '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[15] = '{8'h23, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{8'h23, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[17] = '{8'h1C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[18] = '{8'h23, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[19] = '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[20] = '{8'h23, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[21] = '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[22] = '{8'h1C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[23] = '{8'hE0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[24] = '{8'h6B, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[25] = '{8'h6B, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[26] = '{8'h1C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_code", code, 8'h00);
    check("rst_code_valid", code_valid, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_m_left", m_left, 1'b0);
    check("rst_m_right", m_right, 1'b0);

    for (int i = 0; i < 27; i++)
      run_byte(vecs[i].d, vecs[i].bad_par, vecs[i].bad_stop, vecs[i].ml, vecs[i].mr);

    // Partial frame abandoned: start + 3 data bits, then silence
    q.push_back('{1'b1, last_code, 1'b0, 1'b0});
    send_partial(8'h23, 4);
    repeat (TO - 30) @(posedge clk);
    check("no_early_timeout", q.size(), 1);
    repeat (60) @(posedge clk);
    check("timeout_pulse", q.size(), 0);
    q.delete();
    run_byte(8'h23, 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset in the middle of a frame after 5 bits
    send_partial(8'h6B, 5);
    @(posedge clk); #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    last_code = 8'h00;
    @(negedge clk);
    check("mid_rst_code", code, 8'h00);
    check("mid_rst_m_left", m_left, 1'b0);
    check("mid_rst_m_right", m_right, 1'b0);
    check("mid_rst_code_valid", code_valid, 1'b0);
    check("mid_rst_frame_err", frame_err, 1'b0);
    repeat (20) @(posedge clk);
    check("mid_rst_no_pulse", q.size(), 0);
    run_byte(8'hE0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_byte(8'h6B, 1'b0, 1'b0, 1'b1, 1'b0);

    repeat (5) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
